// File: rtl/ring_shift_unit.sv
// Ring shift unit: FIFO-buffered words, each rotated one bit per cycle, then held for the consumer.
// Optional feature macro RING_PARITY_EN adds out_parity (= ^out_data while out_valid is high).
module ring_shift_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_steps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef RING_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 1 + CNT_W + WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, HOLD = 2'd2} state_e;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             head_ok_q;
  logic             wr_en, rd_en;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  assign in_ready = (count_q != FULL_CNT);
  assign wr_en    = in_valid & in_ready;
  assign rd_en    = (state_q == IDLE) & head_ok_q;

  // Storage array with registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_dir, in_steps, in_data};
    rd_data_q <= mem_q[rd_ptr_q];
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // rd_data_q is trustworthy only if the head entry already existed at the capture
  // edge and the read pointer did not move on that edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_ok_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      head_ok_q <= (count_q != '0) & ~rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (head_ok_q) begin
          work_d  = rd_data_q[WIDTH-1:0];
          cnt_d   = rd_data_q[WIDTH +: CNT_W];
          dir_d   = rd_data_q[ENT_W-1];
          state_d = (rd_data_q[WIDTH +: CNT_W] == '0) ? HOLD : ROTATE;
        end
      end
      ROTATE: begin
        work_d = dir_q ? {work_q[0], work_q[WIDTH-1:1]}
                       : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_valid ? work_q : '0;
  assign busy      = (state_q != IDLE) | (count_q != '0);

`ifdef RING_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk) begin
    if (!reset_n) parity_q <= 1'b0;
    else          parity_q <= (state_d == HOLD) ? ^work_d : 1'b0;
  end
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_ring_shift_unit.sv
// Directed self-checking bench for ring_shift_unit (WIDTH=8, DEPTH=4, CNT_W=3).
module tb_ring_shift_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic [2:0] in_steps;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef RING_PARITY_EN
  logic       out_parity;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  ring_shift_unit #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_steps  (in_steps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef RING_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic dir, input logic [2:0] st,
                      input logic exp_rdy, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_steps = st;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    step();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a result, optionally stalls it, then consumes it.
  task automatic get_out(input logic [7:0] exp, input int stall, input string tag);
    int k = 0;
    while (!out_valid && k < 60) begin
      step();
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      step();
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    int k;
    int seen;
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_dir    = 1'b0;
    in_steps  = 3'd0;
    out_ready = 1'b1;
    #1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    step();
    check("rst_nothing_stored", 32'(busy), 32'd0);

    // Single word: latency push+2+steps, result valid for one clock.
    push(8'h01, 1'b0, 3'd3, 1'b1, "lat");
    k = 0;
    while (!out_valid && k < 60) begin
      step();
      k++;
    end
    check("lat_cycles", 32'(k), 32'd5);
    check("lat_data", 32'(out_data), 32'h08);
`ifdef RING_PARITY_EN
    check("lat_parity", 32'(out_parity), 32'd1);
`endif
    step();
    check("lat_one_clk", 32'(out_valid), 32'd0);

    // Right rotation, then a zero-step word; order preserved.
    push(8'h01, 1'b1, 3'd1, 1'b1, "r1");
    push(8'hA5, 1'b0, 3'd0, 1'b1, "z0");
    get_out(8'h80, 0, "r1");
    get_out(8'hA5, 0, "z0");

    // Backpressure: DEPTH + 1 words accepted, sixth refused.
    out_ready = 1'b0;
    push(8'h11, 1'b0, 3'd1, 1'b1, "bp0");
    push(8'h80, 1'b0, 3'd2, 1'b1, "bp1");
    push(8'hC3, 1'b1, 3'd4, 1'b1, "bp2");
    push(8'h5A, 1'b0, 3'd0, 1'b1, "bp3");
    push(8'h01, 1'b1, 3'd7, 1'b1, "bp4");
    push(8'hFF, 1'b0, 3'd0, 1'b0, "bp5");
    get_out(8'h22, 3, "bp0");
    get_out(8'h02, 2, "bp1");
    get_out(8'h3C, 2, "bp2");
    get_out(8'h5A, 2, "bp3");
    get_out(8'h02, 2, "bp4");
    repeat (4) step();
    check("bp_drained_valid", 32'(out_valid), 32'd0);
    check("bp_drained_busy", 32'(busy), 32'd0);

    // Reset in the middle of a rotation discards the word.
    push(8'h0F, 1'b0, 3'd7, 1'b1, "ab");
    repeat (4) step();
    check("ab_busy_rotating", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("ab_no_output", 32'(seen), 32'd0);
    push(8'h03, 1'b0, 3'd2, 1'b1, "ab_next");
    get_out(8'h0C, 0, "ab_next");

`ifdef RING_PARITY_EN
    check("par_idle", 32'(out_parity), 32'd0);
    push(8'h07, 1'b0, 3'd1, 1'b1, "par1");
    k = 0;
    while (!out_valid && k < 60) begin
      step();
      k++;
    end
    check("par1_data", 32'(out_data), 32'h0E);
    check("par1_parity", 32'(out_parity), 32'd1);
    step();
    push(8'h03, 1'b0, 3'd0, 1'b1, "par0");
    k = 0;
    while (!out_valid && k < 60) begin
      step();
      k++;
    end
    check("par0_data", 32'(out_data), 32'h03);
    check("par0_parity", 32'(out_parity), 32'd0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
